loop_ctrl_fsm: RTL

//  Sequencing controller sitting directly upstream of the loop-index counter.

---
 rtl/loop_ctrl_fsm.sv | 102 ++++++++++
 1 files changed

// File: rtl/loop_ctrl_fsm.sv
// Sequencing controller for the loop-index counter: loads the start index,
// issues one step request per iteration and reports completion or abort.
module loop_ctrl_fsm #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] init_val_i,
  input  logic [CNT_W-1:0] last_val_i,
  input  logic [CNT_W-1:0] cnt_val_i,
  input  logic             step_done_i,
  output logic             cnt_clear_o,
  output logic             cnt_load_o,
  output logic             cnt_en_o,
  output logic [CNT_W-1:0] cnt_data_o,
  output logic             step_req_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_STEP = 3'd2,
    S_WAIT = 3'd3,
    S_NEXT = 3'd4,
    S_DONE = 3'd5,
    S_ABRT = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] init_q, init_d;
  logic [CNT_W-1:0] last_q, last_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      init_q  <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      last_q  <= last_d;
    end
  end

  // Loop bounds are captured only when a start is accepted, so a start
  // arriving mid-loop cannot disturb the iteration in progress.
  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LOAD;
          init_d  = init_val_i;
          last_d  = last_val_i;
        end
      end
      S_LOAD: state_d = abort_i ? S_ABRT : S_STEP;
      S_STEP: state_d = abort_i ? S_ABRT : S_WAIT;
      S_WAIT: begin
        if (abort_i) begin
          state_d = S_ABRT;
        end else if (step_done_i) begin
          state_d = (cnt_val_i == last_q) ? S_DONE : S_NEXT;
        end
      end
      S_NEXT: state_d = abort_i ? S_ABRT : S_STEP;
      S_DONE: state_d = S_IDLE;
      S_ABRT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs: a pure decode of the registered state.
  always_comb begin
    cnt_clear_o = 1'b0;
    cnt_load_o  = 1'b0;
    cnt_en_o    = 1'b0;
    step_req_o  = 1'b0;
    done_o      = 1'b0;
    busy_o      = (state_q != S_IDLE);
    unique case (state_q)
      S_LOAD: cnt_load_o = 1'b1;
      S_STEP: step_req_o = 1'b1;
      S_NEXT: cnt_en_o   = 1'b1;
      S_DONE: begin
        done_o      = 1'b1;
        cnt_clear_o = 1'b1;
      end
      S_ABRT: cnt_clear_o = 1'b1;
      default: ;
    endcase
  end

  assign cnt_data_o = init_q;

endmodule
